sccb_target: RTL
================

SCCB_TARGET -- requirements
Module: sccb_target

Interface
REQ-001 SHALL have parameter WRITE_ID, default 8'h42, meaning the device write address byte (R/W bit = 0).
REQ-002 SHALL have parameter READ_ID, default 8'h43, meaning the device read address byte (R/W bit = 1).
REQ-003 SHALL have port GLOBAL_CLK, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port RESET_N, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port SIOC, input, 1 bit: serial clock from the initiator, asynchronous to GLOBAL_CLK.
REQ-006 SHALL have port SIOD_IN, input, 1 bit: sampled level of the serial data line.
REQ-007 SHALL have port SIOD_OE, output, 1 bit: 1 means pull SIOD low; 0 means release the line.
REQ-008 SHALL have port WR_STROBE, output, 1 bit: single-cycle register-write pulse.
REQ-009 SHALL have port WR_ADDR, output, 8 bits: register subaddress of the write.
REQ-010 SHALL have port WR_DATA, output, 8 bits: register write value.
REQ-011 SHALL have port RD_ADDR, output, 8 bits: subaddress whose value is presented on RD_DATA.
REQ-012 SHALL have port RD_DATA, input, 8 bits: register value, valid combinationally for RD_ADDR.
REQ-013 SHALL have port BUSY, output, 1 bit: 1 from a START to the following STOP.

Function
REQ-014 SHALL pass SIOC and SIOD_IN through 2-flop synchronizers plus one history flop each; edges SHALL be detected on the synchronized signals only.
REQ-015 SHALL operate correctly when the GLOBAL_CLK frequency is at least 8x the SIOC frequency.
REQ-016 SHALL detect START when SIOD falls while SIOC is high, and STOP when SIOD rises while SIOC is high.
REQ-017 SHALL sample data bits on SIOC rising edges, MSB first, and change SIOD_OE only on SIOC falling edges.
REQ-018 SHALL implement the states IDLE, DEV, DEV_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-019 SHALL enter DEV on START from any state, including a repeated START mid-transfer; the bit counter SHALL clear to 0.
REQ-020 SHALL enter IDLE on STOP from any state, release SIOD_OE, and deassert BUSY on the cycle after detection.
REQ-021 After 8 DEV bits, a byte equal to WRITE_ID SHALL go to DEV_ACK and then SUB.
REQ-022 After 8 DEV bits, a byte equal to READ_ID SHALL go to DEV_ACK and then RDATA.
REQ-023 After 8 DEV bits, any other byte SHALL go to IDLE with no ACK driven, ignoring the line until the next START.
REQ-024 Each ACK state SHALL assert SIOD_OE from the SIOC falling edge after bit 8 until the next SIOC falling edge.
REQ-025 The 8 SUB bits SHALL load the 8-bit subaddress pointer; the state SHALL then go SUB_ACK, then WDATA.
REQ-026 After 8 WDATA bits, WR_STROBE SHALL pulse for exactly one GLOBAL_CLK cycle, 1 cycle after the 8th bit's synchronized rising edge, with WR_ADDR = pointer and WR_DATA = byte.
REQ-027 After each WDATA byte, the state SHALL go WDATA_ACK then WDATA again, and the pointer SHALL increment, wrapping 8'hFF -> 8'h00.
REQ-028 RD_ADDR SHALL always equal the pointer.
REQ-029 RD_DATA SHALL be latched into a shift register on entry to RDATA.
REQ-030 In RDATA, each bit SHALL drive SIOD_OE = ~bit, MSB first, updating on SIOC falling edges.
REQ-031 After 8 read bits, SIOD_OE SHALL release and the pointer SHALL increment with wrap.
REQ-032 In RDATA_ACK, the initiator's ACK bit sampled at 0 SHALL return the state to RDATA with the next byte; a NACK (1) SHALL go to IDLE.
REQ-033 WR_STROBE SHALL never assert outside WDATA completion, and SHALL not assert for a WDATA byte cut short by START or STOP.

Reset
REQ-034 SHALL clear all state asynchronously while RESET_N = 0: state = IDLE, pointer = 0, SIOD_OE = 0, WR_STROBE = 0, WR_ADDR = 0, WR_DATA = 0, BUSY = 0.
REQ-035 SHALL preset the synchronizer and history flops for SIOC and SIOD to 1 (idle bus) in reset.
REQ-036 On RESET_N deassertion mid-transfer, SHALL remain IDLE until a fresh START.

Verification
REQ-037 The bench SHALL cover a write: START, 0x42, 0x12, 0x80, STOP -> three ACK low pulses; one WR_STROBE with WR_ADDR = 0x12, WR_DATA = 0x80; BUSY low after STOP.
REQ-038 The bench SHALL cover a burst write: START, 0x42, 0xFE, 0x11, 0x22, 0x33, STOP -> strobes (0xFE,0x11), (0xFF,0x22), (0x00,0x33).
REQ-039 The bench SHALL cover a read: write pointer 0x0A, then START, 0x43, with RD_DATA = 0xA5 -> SIOD carries 1010_0101; master NACK -> IDLE, RD_ADDR = 0x0B.
REQ-040 The bench SHALL cover an address mismatch: START, 0x60, 0x12, 0x80, STOP -> SIOD_OE never asserts, no WR_STROBE.
REQ-041 The bench SHALL cover a repeated START: START, 0x42, 0x05, START, 0x43 -> read of register 0x05, no WR_STROBE.
REQ-042 The bench SHALL cover reset mid-transfer: RESET_N low during bit 4 of WDATA -> SIOD_OE = 0, no strobe, pointer = 0; the next full write succeeds.

Source files
------------

// File: rtl/sccb_target.sv
// SCCB (I2C-like) register-access target.
// Oversamples SIOC/SIOD with GLOBAL_CLK, decodes START/STOP and bit edges,
// and runs a byte-level FSM that handles device-address, subaddress, write-data
// and read-data phases with an auto-incrementing register pointer.
module sccb_target #(
  parameter logic [7:0] WRITE_ID = 8'h42,
  parameter logic [7:0] READ_ID  = 8'h43
) (
  input  logic       GLOBAL_CLK,
  input  logic       RESET_N,
  input  logic       SIOC,
  input  logic       SIOD_IN,
  output logic       SIOD_OE,
  output logic       WR_STROBE,
  output logic [7:0] WR_ADDR,
  output logic [7:0] WR_DATA,
  output logic [7:0] RD_ADDR,
  input  logic [7:0] RD_DATA,
  output logic       BUSY
);

  typedef enum logic [3:0] {
    IDLE,
    DEV,
    DEV_ACK,
    SUB,
    SUB_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK
  } state_t;

  // Synchronizer and history flops (preset to idle-bus level)
  logic sioc_s1, sioc_s2, sioc_h;
  logic siod_s1, siod_s2, siod_h;

  // Decoded bus events
  logic sioc_rise, sioc_fall;
  logic start_det, stop_det;

  // FSM state and datapath registers
  state_t     state, state_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n;
  logic [7:0] ptr, ptr_n;
  logic       oe_n;
  logic       strobe_n;
  logic [7:0] wr_addr_n, wr_data_n;
  logic       busy_n;
  logic [7:0] rx_byte;

  // Two-flop synchronizers plus one history flop per bus line
  always_ff @(posedge GLOBAL_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sioc_s1 <= 1'b1;
      sioc_s2 <= 1'b1;
      sioc_h  <= 1'b1;
      siod_s1 <= 1'b1;
      siod_s2 <= 1'b1;
      siod_h  <= 1'b1;
    end else begin
      sioc_s1 <= SIOC;
      sioc_s2 <= sioc_s1;
      sioc_h  <= sioc_s2;
      siod_s1 <= SIOD_IN;
      siod_s2 <= siod_s1;
      siod_h  <= siod_s2;
    end
  end

  // Edge and bus-condition decode on synchronized signals only
  always_comb begin
    sioc_rise = sioc_s2 & ~sioc_h;
    sioc_fall = ~sioc_s2 & sioc_h;
    start_det = sioc_s2 & sioc_h & siod_h & ~siod_s2;
    stop_det  = sioc_s2 & sioc_h & ~siod_h & siod_s2;
  end

  // State and datapath registers
  always_ff @(posedge GLOBAL_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      ptr       <= '0;
      SIOD_OE   <= 1'b0;
      WR_STROBE <= 1'b0;
      WR_ADDR   <= '0;
      WR_DATA   <= '0;
      BUSY      <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      ptr       <= ptr_n;
      SIOD_OE   <= oe_n;
      WR_STROBE <= strobe_n;
      WR_ADDR   <= wr_addr_n;
      WR_DATA   <= wr_data_n;
      BUSY      <= busy_n;
    end
  end

  // Next-state and next-output logic; START/STOP override every state
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    ptr_n     = ptr;
    oe_n      = SIOD_OE;
    strobe_n  = 1'b0;
    wr_addr_n = WR_ADDR;
    wr_data_n = WR_DATA;
    busy_n    = BUSY;
    rx_byte   = {shreg[6:0], siod_s2};

    if (start_det) begin
      state_n   = DEV;
      bit_cnt_n = '0;
      oe_n      = 1'b0;
      busy_n    = 1'b1;
    end else if (stop_det) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      oe_n      = 1'b0;
      busy_n    = 1'b0;
    end else begin
      case (state)
        DEV: begin
          if (sioc_rise && bit_cnt < 4'd8) begin
            shreg_n   = rx_byte;
            bit_cnt_n = bit_cnt + 4'd1;
            // Foreign address: drop off the bus without acknowledging
            if (bit_cnt == 4'd7 && rx_byte != WRITE_ID && rx_byte != READ_ID)
              state_n = IDLE;
          end else if (sioc_fall && bit_cnt == 4'd8) begin
            state_n = DEV_ACK;
            oe_n    = 1'b1;
          end
        end

        DEV_ACK: begin
          if (sioc_fall) begin
            bit_cnt_n = '0;
            // shreg still holds the address byte, so it selects the direction
            if (shreg == READ_ID) begin
              state_n = RDATA;
              shreg_n = RD_DATA;
              oe_n    = ~RD_DATA[7];
            end else begin
              state_n = SUB;
              oe_n    = 1'b0;
            end
          end
        end

        SUB: begin
          if (sioc_rise && bit_cnt < 4'd8) begin
            shreg_n   = rx_byte;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7)
              ptr_n = rx_byte;
          end else if (sioc_fall && bit_cnt == 4'd8) begin
            state_n = SUB_ACK;
            oe_n    = 1'b1;
          end
        end

        SUB_ACK: begin
          if (sioc_fall) begin
            state_n   = WDATA;
            bit_cnt_n = '0;
            oe_n      = 1'b0;
          end
        end

        WDATA: begin
          if (sioc_rise && bit_cnt < 4'd8) begin
            shreg_n   = rx_byte;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              strobe_n  = 1'b1;
              wr_addr_n = ptr;
              wr_data_n = rx_byte;
              ptr_n     = ptr + 8'd1;
            end
          end else if (sioc_fall && bit_cnt == 4'd8) begin
            state_n = WDATA_ACK;
            oe_n    = 1'b1;
          end
        end

        WDATA_ACK: begin
          if (sioc_fall) begin
            state_n   = WDATA;
            bit_cnt_n = '0;
            oe_n      = 1'b0;
          end
        end

        RDATA: begin
          if (sioc_rise && bit_cnt < 4'd8) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (sioc_fall && bit_cnt == 4'd8) begin
            state_n   = RDATA_ACK;
            bit_cnt_n = '0;
            oe_n      = 1'b0;
            ptr_n     = ptr + 8'd1;
          end else if (sioc_fall && bit_cnt != 4'd0) begin
            // shreg[7] is the bit on the line; advance to the next one
            shreg_n = {shreg[6:0], 1'b0};
            oe_n    = ~shreg[6];
          end
        end

        RDATA_ACK: begin
          if (sioc_rise && siod_s2) begin
            state_n = IDLE;
          end else if (sioc_fall) begin
            state_n   = RDATA;
            bit_cnt_n = '0;
            shreg_n   = RD_DATA;
            oe_n      = ~RD_DATA[7];
          end
        end

        default: ;
      endcase
    end
  end

  assign RD_ADDR = ptr;

endmodule
